// File: rtl/lfsr_encrypt_engine.sv
// lfsr_encrypt_engine
// Encrypts a plaintext message held in data memory. It first reads three
// configuration bytes: the preamble length, the LFSR tap mask and the LFSR seed.
// It then forms a 64-byte padded stream: leading spaces, the message, and
// trailing spaces. Each stream byte has its low 7 bits XORed with the current
// state of a 7-bit LFSR. Bit 7 of each output byte is replaced by the parity of
// bits [6:0]. The 64 ciphertext bytes are written back starting at OUT_BASE.
//
// Ports
//   Clk          in   single clock, rising edge
//   Reset        in   synchronous, active-high
//   Start        in   1 = hold idle; a run begins on the edge that samples 0
//   Ack          out  1 = run complete (held until Start returns to 1)
//   mem_addr     out  data-memory address
//   mem_rd_data  in   combinational read data for mem_addr
//   mem_wr_en    out  write strobe; memory writes on the rising edge
//   mem_wr_data  out  write data
//   o_dbg_state  out  current FSM state encoding, for observation only
//
// Handshake: Start/Ack is a level handshake. Start low requests a run, which
// executes to completion regardless of further Start activity. Ack then stays
// high. Raising Start returns the block to idle and clears Ack. A new run needs
// Start to go low again.
module lfsr_encrypt_engine (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [2:0] o_dbg_state
);

  localparam logic [7:0] MSG_BASE  = 8'd0;
  localparam logic [7:0] CFG_BASE  = 8'd61;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam logic [6:0] LAST_BYTE = 7'd63;   // NBYTES - 1
  localparam logic [6:0] MSG_LAST  = 7'd60;   // last plaintext offset

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_PRE  = 3'd1,
    S_LD_TAP  = 3'd2,
    S_LD_SEED = 3'd3,
    S_RD      = 3'd4,
    S_WR      = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t     r_state;
  logic [3:0] r_pre;
  logic [6:0] r_tap;
  logic [6:0] r_lfsr;
  logic [6:0] r_i;
  logic [7:0] r_pt;

  logic [6:0] w_pre7;
  logic [6:0] w_off;
  logic       w_is_pad;
  logic [6:0] w_c;
  logic       w_fb;
  logic       w_unused_pt_msb;

  assign w_pre7 = {3'b000, r_pre};
  // The offset is only meaningful when r_i >= r_pre. The r_i < pre term in
  // w_is_pad masks out the wrapped value.
  assign w_off    = r_i - w_pre7;
  assign w_is_pad = (r_i < w_pre7) || (w_off > MSG_LAST);
  assign w_c      = r_pt[6:0] ^ r_lfsr;
  assign w_fb     = ^(r_lfsr & r_tap);
  // The plaintext MSB is latched but never used, because parity replaces it.
  assign w_unused_pt_msb = r_pt[7];

  assign o_dbg_state = r_state;

  // Outputs are decoded only from registers. Start has no path to them.
  always_comb begin
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    Ack         = 1'b0;
    case (r_state)
      S_LD_PRE:  mem_addr = CFG_BASE;
      S_LD_TAP:  mem_addr = CFG_BASE + 8'd1;
      S_LD_SEED: mem_addr = CFG_BASE + 8'd2;
      S_RD:      if (!w_is_pad) mem_addr = MSG_BASE + {1'b0, w_off};
      S_WR: begin
        mem_addr    = OUT_BASE + {1'b0, r_i};
        mem_wr_en   = 1'b1;
        mem_wr_data = {^w_c, w_c};
      end
      S_DONE:    Ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pre   <= 4'd0;
      r_tap   <= 7'd0;
      r_lfsr  <= 7'd0;
      r_i     <= 7'd0;
      r_pt    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (!Start) r_state <= S_LD_PRE;
        S_LD_PRE: begin
          // A preamble shorter than 10 is raised to 10.
          r_pre   <= (mem_rd_data[3:0] < 4'd10) ? 4'd10 : mem_rd_data[3:0];
          r_state <= S_LD_TAP;
        end
        S_LD_TAP: begin
          r_tap   <= mem_rd_data[6:0];
          r_state <= S_LD_SEED;
        end
        S_LD_SEED: begin
          // An all-zero seed would lock the LFSR, so it is replaced with 1.
          r_lfsr  <= (mem_rd_data[6:0] == 7'd0) ? 7'h01 : mem_rd_data[6:0];
          r_i     <= 7'd0;
          r_state <= S_RD;
        end
        S_RD: begin
          r_pt    <= w_is_pad ? 8'h20 : mem_rd_data;
          r_state <= S_WR;
        end
        S_WR: begin
          r_lfsr  <= {r_lfsr[5:0], w_fb};
          r_i     <= r_i + 7'd1;
          r_state <= (r_i < LAST_BYTE) ? S_RD : S_DONE;
        end
        S_DONE: if (Start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
module tb_lfsr_encrypt_engine;

  // ---------------- clock / reset / DUT ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [2:0] dbg_state;

  always #5 Clk = ~Clk;

  lfsr_encrypt_engine dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Ack         (Ack),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .o_dbg_state (dbg_state)
  );

  // Data memory: combinational read, writes on the rising edge.
  // The bench loads memory through a host port while the DUT is not writing.
  logic [7:0] mem [256];
  logic       h_we;
  logic [7:0] h_addr;
  logic [7:0] h_data;
  int         wr_cnt = 0;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge Clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt        <= wr_cnt + 1;
    end else if (h_we) begin
      mem[h_addr] <= h_data;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] pt_buf[61];
  logic [7:0] saved[64];
  logic [7:0] taps[9] = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
  string      msg = "Mr. Watson, come here. I want to see you.";
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hwrite(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    h_we = 1'b1; h_addr = a; h_data = d;
  endtask

  // mode 0: random bytes, mode 1: message then spaces, mode 2: bit 7 always set
  task automatic gen_pt(input int mode);
    for (int k = 0; k < 61; k++) begin
      case (mode)
        0: pt_buf[k] = 8'($urandom_range(0, 255));
        1: pt_buf[k] = (k < msg.len()) ? msg[k] : 8'h20;
        default: pt_buf[k] = (k % 3 == 0) ? 8'h9F : (8'h80 | 8'($urandom_range(0, 127)));
      endcase
    end
  endtask

  // Writes the plaintext, the configuration, and a poisoned output region.
  task automatic load(input logic [7:0] pre_b, input logic [7:0] tap_b, input logic [7:0] seed_b);
    for (int k = 0; k < 61; k++) hwrite(8'(k), pt_buf[k]);
    hwrite(8'd61, pre_b);
    hwrite(8'd62, tap_b);
    hwrite(8'd63, seed_b);
    for (int k = 64; k < 128; k++) hwrite(8'(k), 8'hEE);
    @(negedge Clk);
    h_we = 1'b0;
  endtask

  // Reference model: the padded stream, LFSR state sequence and parity byte,
  // computed directly from the memory image.
  task automatic build_expected();
    int         pre;
    logic [6:0] st;
    logic [6:0] tap;
    logic [6:0] c;
    logic [7:0] p;
    pre = int'(mem[61][3:0]);
    if (pre < 10) pre = 10;
    tap = mem[62][6:0];
    st  = mem[63][6:0];
    if (st == 7'd0) st = 7'd1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      p = (i < pre || (i - pre) > 60) ? 8'h20 : mem[i - pre];
      c = p[6:0] ^ st;
      exp_q.push_back({^c, c});
      st = {st[5:0], ^(st & tap)};
    end
  endtask

  // Called right after edge 0. Checks Ack latency, write count and the bytes.
  task automatic finish_run(input string name, input int base);
    int lat;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge Clk); #1;
      if (Ack === 1'b1) begin lat = e; break; end
    end
    check({name, "_ack_latency"}, lat, 131);
    check({name, "_write_count"}, wr_cnt - base, 64);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_out[%0d]", name, i), mem[64 + i], exp_q.pop_front());
  endtask

  task automatic run_and_check(input string name);
    int base;
    build_expected();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    base = wr_cnt;
    @(posedge Clk);   // edge 0
    finish_run(name, base);
  endtask

  // Inverse check: decrypts the written region and compares it with the
  // padded message.
  task automatic decrypt_score(input string name);
    int         pre;
    int         good;
    logic [6:0] st;
    logic [6:0] tap;
    logic [7:0] c;
    logic [6:0] want;
    pre = int'(mem[61][3:0]);
    if (pre < 10) pre = 10;
    tap = mem[62][6:0];
    st  = mem[63][6:0];
    if (st == 7'd0) st = 7'd1;
    good = 0;
    for (int i = 0; i < 64; i++) begin
      c    = mem[64 + i];
      want = (i < pre) ? 7'h20 : pt_buf[i - pre][6:0];
      if (((c[6:0] ^ st) == want) && (c[7] == ^c[6:0])) good++;
      st = {st[5:0], ^(st & tap)};
    end
    check({name, "_decrypt_score"}, good, 64);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int diffs;
    int base;
    int bad;
    logic [7:0] pre_b;
    logic [7:0] tap_b;
    logic [7:0] seed_b;

    Reset = 1'b1; Start = 1'b1; h_we = 1'b0; h_addr = 8'd0; h_data = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ack", Ack, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    check("rst_state", dbg_state, 0);
    @(negedge Clk); Reset = 1'b0;

    // Directed vector: seed 1, tap 0x5C, pre 10.
    gen_pt(0);
    load(8'h0A, 8'h5C, 8'h01);
    run_and_check("directed");
    check("dir_out64", mem[64], 8'h21);
    check("dir_out65", mem[65], 8'h22);
    check("dir_out66", mem[66], 8'h24);
    check("dir_out67", mem[67], 8'hA9);
    for (int i = 0; i < 64; i++) saved[i] = mem[64 + i];

    // Holding Start low in DONE must not cause any further writes.
    base = wr_cnt;
    repeat (20) @(posedge Clk);
    #1;
    check("done_hold_ack", Ack, 1);
    check("done_hold_writes", wr_cnt - base, 0);
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1;
    check("done_exit_ack", Ack, 0);
    check("done_exit_wr_en", mem_wr_en, 0);

    // Seed 0 must behave exactly like seed 1.
    load(8'h0A, 8'h5C, 8'h00);
    run_and_check("seed0");
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i] !== saved[i]) diffs++;
    check("seed0_same_as_seed1", diffs, 0);

    // pre = 3 must be clamped to 10.
    load(8'h03, 8'h5C, 8'h01);
    run_and_check("pre3");
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i] !== saved[i]) diffs++;
    check("pre3_same_as_pre10", diffs, 0);

    // Message runs with random tap, seed and preamble.
    gen_pt(1);
    for (int r = 0; r < 3; r++) begin
      tap_b  = {1'($urandom_range(0, 1)), taps[$urandom_range(0, 8)][6:0]};
      seed_b = 8'($urandom_range(0, 255));
      pre_b  = {4'($urandom_range(0, 15)), 4'(10 + $urandom_range(0, 5))};
      load(pre_b, tap_b, seed_b);
      run_and_check($sformatf("msg%0d", r));
      decrypt_score($sformatf("msg%0d", r));
    end

    // Plaintext MSBs set: every output bit 7 must be parity, not the MSB.
    gen_pt(2);
    load(8'($urandom_range(0, 255)), taps[$urandom_range(0, 8)], 8'($urandom_range(0, 255)));
    run_and_check("msb");
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i][7] !== ^mem[64 + i][6:0]) bad++;
    check("msb_parity", bad, 0);

    // Mid-run reset, then the run restarts as soon as Reset is released
    // while Start is still low.
    gen_pt(0);
    load(8'h0C, 8'h60, 8'h35);
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    @(posedge Clk);                 // edge 0
    repeat (50) @(posedge Clk);     // edge 50
    #1 Reset = 1'b1;
    @(posedge Clk); #1;             // edge 51
    check("midrst_wr_en", mem_wr_en, 0);
    check("midrst_ack", Ack, 0);
    check("midrst_addr", mem_addr, 0);
    // While Reset is held with Start low, the engine stays idle. The output
    // region is cleared during this time so that the rerun must rewrite it.
    for (int k = 64; k < 128; k++) hwrite(8'(k), 8'hEE);
    @(negedge Clk); h_we = 1'b0;
    #1;
    check("rst_wins_state", dbg_state, 0);
    check("rst_wins_addr", mem_addr, 0);
    build_expected();
    base = wr_cnt;
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk);                 // edge 0 of the rerun
    finish_run("rerun_release", base);

    // A full rerun through a Start pulse.
    load(8'h0C, 8'h60, 8'h35);
    run_and_check("rerun_pulse");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
